// File: rtl/sat_counter_pkg.sv
// sat_counter_pkg: shared definitions for the saturating counter table.
//   - upd_op_e       : update opcode encodings (hold / increment / decrement / write)
//   - sweep_state_e  : attenuation sweep FSM states
//   - sat_inc/sat_dec: saturating arithmetic on a zero-extended counter value;
//                      sat_inc takes the live counter width so one function
//                      serves every table width up to MAX_CNT_W bits.
package sat_counter_pkg;

    localparam int unsigned MAX_CNT_W = 16;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_WR   = 2'b11
    } upd_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_e;

    // Increment that sticks at 2^width-1.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(
        input logic [MAX_CNT_W-1:0] val,
        input int unsigned          width
    );
        logic [MAX_CNT_W-1:0] max_val;
        // A shift by the full width yields 0, and 0-1 is all ones: still correct.
        max_val = (MAX_CNT_W'(1) << width) - MAX_CNT_W'(1);
        sat_inc = (val >= max_val) ? max_val : val + MAX_CNT_W'(1);
    endfunction

    // Decrement that sticks at 0; independent of width since the value is zero-extended.
    function automatic logic [MAX_CNT_W-1:0] sat_dec(
        input logic [MAX_CNT_W-1:0] val
    );
        sat_dec = (val == '0) ? '0 : val - MAX_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sat_counter_sweep_ctrl.sv
// sat_counter_sweep_ctrl: attenuation sweep sequencer.
// Walks the table one group of LANES entries per cycle after an attenuation
// request; a request arriving while a sweep runs (including its final cycle)
// is remembered and starts a new sweep back-to-back. Extra requests collapse.
//   clk, rst_n : clock, asynchronous active-low reset
//   atten      : one-cycle attenuation request
//   busy       : sweep in progress (a pending sweep only exists while sweeping)
//   grp_vld    : a group is decayed on the coming edge
//   grp_idx    : index of that group (entries grp_idx*LANES .. +LANES-1)
module sat_counter_sweep_ctrl #(
    parameter int unsigned NGRP  = 32,
    parameter int unsigned GRP_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             atten,
    output logic             busy,
    output logic             grp_vld,
    output logic [GRP_W-1:0] grp_idx
);
    import sat_counter_pkg::*;

    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NGRP - 1);

    sweep_state_e     state_q, state_d;
    logic [GRP_W-1:0] ptr_q, ptr_d;
    logic             pend_q, pend_d;
    logic             busy_q, busy_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (atten) begin
                    state_d = ST_SWEEP;
                    ptr_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (ptr_q == LAST_GRP) begin
                    // A request on the final cycle restarts just like a stored one.
                    ptr_d  = '0;
                    pend_d = 1'b0;
                    if (!(pend_q || atten)) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    ptr_d = ptr_q + GRP_W'(1);
                    if (atten) begin
                        pend_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
        busy_d = (state_d == ST_SWEEP);
    end

    // busy_q tracks state_q == ST_SWEEP, so it also qualifies the group.
    assign busy    = busy_q;
    assign grp_vld = busy_q;
    assign grp_idx = ptr_q;

endmodule

// File: rtl/sat_counter_table.sv
// sat_counter_table: table of DEPTH saturating counters of CNT_W bits.
//   Clk, Rest        : clock, asynchronous active-low reset
//   Atten/AttenBusy  : attenuation request / sweep in progress
//   RdEn/RdAddr      : read strobe and address; RdData is registered,
//                      read-before-write, and holds when RdEn is low
//   UpdEn/UpdAddr    : update strobe and address
//   UpdOp/UpdDin     : 00 hold, 01 inc, 10 dec, 11 write UpdDin
// An update hitting the group being swept wins over that entry's decay.
module sat_counter_table #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned LANES  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Rest,
    input  logic              Atten,
    output logic              AttenBusy,
    input  logic              RdEn,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic [CNT_W-1:0]  RdData,
    input  logic              UpdEn,
    input  logic [ADDR_W-1:0] UpdAddr,
    input  logic [1:0]        UpdOp,
    input  logic [CNT_W-1:0]  UpdDin
);
    import sat_counter_pkg::*;

    localparam int unsigned NGRP  = DEPTH / LANES;
    localparam int unsigned GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    logic [CNT_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic [CNT_W-1:0] upd_val_c;
    logic             grp_vld;
    logic [GRP_W-1:0] grp_idx;

    // Sweep sequencer.
    sat_counter_sweep_ctrl #(
        .NGRP  (NGRP),
        .GRP_W (GRP_W)
    ) u_sweep_ctrl (
        .clk     (Clk),
        .rst_n   (Rest),
        .atten   (Atten),
        .busy    (AttenBusy),
        .grp_vld (grp_vld),
        .grp_idx (grp_idx)
    );

    // Result of the requested update on the addressed entry.
    always_comb begin
        upd_val_c = mem_q[UpdAddr];
        case (upd_op_e'(UpdOp))
            OP_HOLD: upd_val_c = mem_q[UpdAddr];
            OP_INC:  upd_val_c = CNT_W'(sat_inc(MAX_CNT_W'(mem_q[UpdAddr]), CNT_W));
            OP_DEC:  upd_val_c = CNT_W'(sat_dec(MAX_CNT_W'(mem_q[UpdAddr])));
            OP_WR:   upd_val_c = UpdDin;
        endcase
    end

    // Per-entry merge: decay for the active group, then the update overrides.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (grp_vld && ((i / LANES) == 32'(grp_idx))) begin
                mem_d[i] = CNT_W'(sat_dec(MAX_CNT_W'(mem_q[i])));
            end
            if (UpdEn && (UpdAddr == ADDR_W'(i))) begin
                mem_d[i] = upd_val_c;
            end
        end
    end

    // Read register samples the pre-edge contents.
    always_comb begin
        rd_data_d = rd_data_q;
        if (RdEn) begin
            rd_data_d = mem_q[RdAddr];
        end
    end

    // Storage and read register.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_data_q <= rd_data_d;
        end
    end

    assign RdData = rd_data_q;

endmodule
